alu_op_issuer: RTL and testbench

- Sequential front end for the combinational 32-bit gate-level ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU operand and control inputs, holding them stable.
- Waits a programmed settle interval to cover gate propagation (the zero flag path is the slowest), then captures the result and flags into registers.
- Returns the captured values over a valid/ready response handshake.
- Sits between the control/test sequencer and the ALU datapath.

---
 rtl/alu_op_issuer.sv | 145 ++++++++++++++
 tb/tb_alu_op_issuer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Sequential front end for the combinational 32-bit ALU: registers a request onto the
// ALU inputs, waits out gate propagation, captures result and flags, returns them.
module alu_op_issuer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_a,
  input  logic [31:0]        req_b,
  input  logic [2:0]         req_op,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [2:0]         alu_control,
  input  logic [31:0]        alu_out,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  // state  | meaning
  // IDLE   | ready for a request, ALU inputs hold last issued values
  // SETTLE | ALU inputs stable, counting down gate propagation time
  // RESP   | captured result presented, waiting for consumer
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // A zero settle interval still needs one edge for the ALU inputs to propagate.
  localparam int unsigned SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_EFF - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       handshake;
  logic       arith_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 8'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= 8'd0;
    end else if (accept) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state == SETTLE && settle_cnt != 8'd0) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else if (accept) begin
      alu_a       <= req_a;
      alu_b       <= req_b;
      alu_control <= req_op;
    end
  end

  // Carry and overflow are only meaningful for ADD and SUB.
  assign arith_op = (alu_control == 3'd0) || (alu_control == 3'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result   <= '0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (capture) begin
      rsp_result   <= alu_out;
      rsp_carryout <= alu_carryout & arith_op;
      rsp_overflow <= alu_overflow & arith_op;
      rsp_zero     <= alu_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (handshake) begin
      op_count <= op_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: behavioural ALU on the alu_* ports, directed cases plus
// random operations checked against arithmetic reference values and a response counter.
module tb_alu_op_issuer;
  localparam int S  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_a = '0;
  logic [31:0]   req_b = '0;
  logic [2:0]    req_op = '0;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [2:0]    alu_control;
  logic [31:0]   alu_out;
  logic          alu_carryout;
  logic          alu_overflow;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic          rsp_carryout;
  logic          rsp_overflow;
  logic          rsp_zero;
  logic          busy;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  int last_wait = 0;

  always #5 clk = ~clk;

  alu_op_issuer #(.SETTLE_CYCLES(S), .COUNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return a ^ b;
      3'd4: return a & b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  function automatic logic raw_carry(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    if (op == 3'd0) s = {1'b0, a} + {1'b0, b};
    else s = {1'b0, a} + {1'b0, ~b} + 33'd1;
    return s[32];
  endfunction

  function automatic logic raw_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = ref_result(op, a, b);
    if (op == 3'd0) return (a[31] == b[31]) && (r[31] != a[31]);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  // The ALU drives junk flags on non-arithmetic ops so masking is observable.
  always_comb begin
    alu_out      = ref_result(alu_control, alu_a, alu_b);
    alu_zero     = (alu_out == 32'd0);
    alu_carryout = (alu_control < 3'd2) ? raw_carry(alu_control, alu_a, alu_b) : 1'b1;
    alu_overflow = (alu_control < 3'd2) ? raw_ovf(alu_control, alu_a, alu_b) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int hold, input bit queue_next,
                       input logic [31:0] na, input logic [31:0] nb, input logic [2:0] nop);
    int waits;
    logic [31:0] er;
    logic ec, eo;
    er = ref_result(op, a, b);
    ec = (op < 3'd2) ? raw_carry(op, a, b) : 1'b0;
    eo = (op < 3'd2) ? raw_ovf(op, a, b) : 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    last_wait = waits;
    if (!req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("alu_a_load", alu_a, a);
    chk("alu_b_load", alu_b, b);
    chk("alu_control_load", alu_control, op);
    chk("busy_settle", busy, 1);
    for (int i = 1; i <= S; i++) begin
      @(posedge clk); #1;
      if (i < S) begin
        chk("rsp_valid_early", rsp_valid, 0);
        chk("req_ready_settle", req_ready, 0);
      end
    end
    chk("rsp_valid_rise", rsp_valid, 1);
    chk("rsp_result", rsp_result, er);
    chk("rsp_carryout", rsp_carryout, ec);
    chk("rsp_overflow", rsp_overflow, eo);
    chk("rsp_zero", rsp_zero, (er == 32'd0));
    if (queue_next) begin
      req_valid = 1'b1; req_a = na; req_b = nb; req_op = nop;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_result", rsp_result, er);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_alu_a", alu_a, a);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    chk("op_count", op_count, exp_count);
    chk("rsp_valid_fall", rsp_valid, 0);
    chk("req_ready_idle", req_ready, 1);
    chk("alu_a_held", alu_a, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0] rop;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_alu_a", alu_a, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_rsp_result", rsp_result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("reset_req_ready", req_ready, 1);

    issue(32'h7FFFFFFF, 32'h1, 3'd0, 0, 0, 0, 0, 0);
    issue(32'd5, 32'd5, 3'd1, 0, 0, 0, 0, 0);
    issue(32'hFFFFFFFF, 32'd1, 3'd2, 0, 0, 0, 0, 0);
    issue(32'hF0F0F0F0, 32'h0F0F0F0F, 3'd4, 0, 0, 0, 0, 0);
    // Backpressure with a second request held during RESP.
    issue(32'h12345678, 32'h9ABCDEF0, 3'd3, 10, 1, 32'hCAFEF00D, 32'h0000FFFF, 3'd7);
    issue(32'hCAFEF00D, 32'h0000FFFF, 3'd7, 0, 0, 0, 0, 0);
    chk("reaccept_wait", last_wait, 0);

    // Reset two edges into SETTLE aborts the operation.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'hDEADBEEF; req_b = 32'h1; req_op = 3'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    exp_count = 0;
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_b", alu_b, 0);
    chk("abort_alu_control", alu_control, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_op_count", op_count, 0);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("abort_req_ready", req_ready, 1);
    for (int i = 0; i < S + 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h80000000;
      rop = 3'($urandom_range(0, 7));
      issue(ra, rb, rop, $urandom_range(0, 3), 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
